// File: rtl/spart_pkg.sv
// Shared constants and state encodings for the SPART bus-attached UART.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator: 16-bit down counter, one-clock tick at zero, period div+1.
module spart_baud_gen #(
  parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] div_i,
  input  logic        reload_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 16'd0);

  always_comb begin
    cnt_d = cnt_q - 16'd1;
    if (reload_i || tick_o) cnt_d = div_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= DEFAULT_DIV;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spart.sv
// SPART top: bus decode, divisor registers, 8N1 TX/RX with 16x oversampling.
// Define SPART_ERR_EN to add sticky framing/overrun flags in status bits [3:2].
module spart
  import spart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  logic wr_buf, wr_dbl, wr_dbh, rd_buf, rd_stat;
  logic tick;
  logic [15:0] div_q, div_d;
  logic [7:0]  rd_data;
  logic [1:0]  err;

  assign wr_buf  = iocs & ~iorw & (ioaddr == ADDR_BUF);
  assign wr_dbl  = iocs & ~iorw & (ioaddr == ADDR_DBL);
  assign wr_dbh  = iocs & ~iorw & (ioaddr == ADDR_DBH);
  assign rd_buf  = iocs &  iorw & (ioaddr == ADDR_BUF);
  assign rd_stat = iocs &  iorw & (ioaddr == ADDR_STAT);

  always_comb begin
    div_d = div_q;
    if (wr_dbl) div_d[7:0]  = databus;
    if (wr_dbh) div_d[15:8] = databus;
  end

  // Baud counter reloads with the new divisor on the same edge it is written
  spart_baud_gen #(.DEFAULT_DIV(DEFAULT_DIV)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_i    (div_d),
    .reload_i (wr_dbl | wr_dbh),
    .tick_o   (tick)
  );

  // ---------------- TX ----------------
  tx_state_t   tx_state_q, tx_state_d;
  logic [9:0]  tx_sh_q, tx_sh_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [3:0]  tx_tck_q, tx_tck_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= 10'h3FF;
      tx_bit_q   <= 4'd0;
      tx_tck_q   <= 4'd0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      tx_tck_q   <= tx_tck_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_tck_d   = tx_tck_q;
    case (tx_state_q)
      TX_IDLE: if (wr_buf) begin
        tx_state_d = TX_SHIFT;
        tx_sh_d    = {1'b1, databus, 1'b0};
        tx_bit_d   = 4'd0;
        tx_tck_d   = 4'd0;
      end
      TX_SHIFT: if (tick) begin
        tx_tck_d = tx_tck_q + 4'd1;
        if (tx_tck_q == TICK_LAST) begin
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          tx_bit_d = tx_bit_q + 4'd1;
          if (tx_bit_q == 4'd9) tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tbr = (tx_state_q == TX_IDLE);
    txd = (tx_state_q == TX_SHIFT) ? tx_sh_q[0] : 1'b1;
  end

  // ---------------- RX ----------------
  rx_state_t  rx_state_q, rx_state_d;
  logic       rx_m_q, rx_s_q;
  logic [3:0] rx_tck_q, rx_tck_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic       rda_q, rda_d;
  logic       byte_done, frame_err, overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tck_q   <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_buf_q   <= 8'h00;
      rda_q      <= 1'b0;
      div_q      <= DEFAULT_DIV;
    end else begin
      rx_m_q     <= rxd;
      rx_s_q     <= rx_m_q;
      rx_state_q <= rx_state_d;
      rx_tck_q   <= rx_tck_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
      div_q      <= div_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tck_d   = rx_tck_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!rx_s_q) begin
        rx_state_d = RX_START;
        rx_tck_d   = 4'd0;
      end
      RX_START: if (tick) begin
        rx_tck_d = rx_tck_q + 4'd1;
        if (rx_tck_q == TICK_HALF) begin
          rx_tck_d   = 4'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (tick) begin
        rx_tck_d = rx_tck_q + 4'd1;
        if (rx_tck_q == TICK_LAST) begin
          rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: if (tick) begin
        rx_tck_d = rx_tck_q + 4'd1;
        if (rx_tck_q == TICK_LAST) begin
          byte_done  = rx_s_q;
          frame_err  = ~rx_s_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A read landing with a new byte returns the old one, so that is not an overrun
  always_comb begin
    rx_buf_d = byte_done ? rx_sh_q : rx_buf_q;
    rda_d    = byte_done | (rda_q & ~rd_buf);
    overrun  = byte_done & rda_q & ~rd_buf;
  end

  assign rda = rda_q;

`ifdef SPART_ERR_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d = rd_stat ? 2'b00 : err_q;
    if (frame_err) err_d[0] = 1'b1;
    if (overrun)   err_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 2'b00;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  wire unused_err = &{1'b0, frame_err, overrun, rd_stat};
  assign err = 2'b00;
`endif

  always_comb begin
    case (ioaddr)
      ADDR_BUF:  rd_data = rx_buf_q;
      ADDR_STAT: rd_data = {4'b0000, err, tbr, rda_q};
      ADDR_DBL:  rd_data = div_q[7:0];
      default:   rd_data = div_q[15:8];
    endcase
  end

  assign databus = (iocs & iorw) ? rd_data : 8'bzzzz_zzzz;

endmodule

// File: doc/spart.md
# spart

Special-purpose asynchronous receiver/transmitter (SPART) that answers the processor-side bus cycles issued by the bus driver FSM. It decodes chip-select, read/write and a 2-bit register address, drives or samples the shared 8-bit databus, and reports receive-data-available and transmit-buffer-ready back to the initiator. On the serial side it runs an 8N1 UART with a programmable baud divisor and 16x receive oversampling.

## Interface
- DEFAULT_DIV, 16'd325, divisor loaded at reset; tick period is DEFAULT_DIV+1 clocks (9600 baud ×16 at 50 MHz).
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- iocs  input  1  chip select; bus cycle valid when high
- iorw  input  1  1 = read (SPART drives databus), 0 = write (SPART samples databus)
- ioaddr  input  2  00 TX/RX buffer, 01 status, 10 divisor low byte, 11 divisor high byte
- databus  inout  8  shared data bus; high-Z unless iocs & iorw
- rda  output  1  receive data available
- tbr  output  1  transmit buffer ready
- txd  output  1  serial out, idle high
- rxd  input  1  serial in, asynchronous to clk

## Operation
- Bus decode is combinational per cycle; each cycle with iocs high is one access. No wait states.
- Reads: 00 → rx_buf; 01 → {4'b0, err[1:0], tbr, rda}; 10 → div[7:0]; 11 → div[15:8]. Reading 00 clears rda at the next edge.
- Writes: 00 → load TX if tbr=1, ignored if tbr=0; 01 → ignored; 10/11 → update divisor byte and reload baud counter at the next edge.
- Baud generator: 16-bit down counter; loads div, decrements each clock, emits 1-clock `tick` at 0 and reloads. 16 ticks = one bit time.
- TX FSM, states IDLE → SHIFT: write loads 10-bit shifter {1, data, 0}, bit counter 0, tbr←0. Shifter outputs LSB on txd; advances every 16 ticks; after 10th bit completes returns to IDLE, tbr←1, txd=1.
- RX path: rxd double-flopped before use. RX FSM states IDLE, START, DATA, STOP.
  - IDLE: synchronized rxd low → START, tick counter cleared.
  - START: after 8 ticks sample; low → DATA, high → IDLE (false start, no rda).
  - DATA: sample every 16 ticks, 8 bits LSB first into rx_shift.
  - STOP: sample after 16 ticks; high → rx_buf←rx_shift, rda←1; low → framing error, rx_buf unchanged, rda unchanged. Either way → IDLE.
- New byte completing while rda=1 overwrites rx_buf (overrun); rda stays 1.
- Read of 00 on the same edge a new byte lands: new byte wins, rda remains 1.
- Divisor write mid-frame takes effect immediately; frame in flight is not protected.

## Timing
- Reset values: txd=1, tbr=1, rda=0, rx_buf=0, div=DEFAULT_DIV, databus high-Z, both FSMs IDLE, err=0.
- Read data valid on databus in the same cycle as iocs&iorw (combinational mux from registers).
- TX: txd goes low on the first edge after the accepted write; each bit lasts 16·(div+1) clocks; tbr returns high when the stop bit finishes, i.e. 160·(div+1) clocks after the write, ±1 tick alignment.
- RX: rda rises 1 clock after the stop-bit sample; sampling point is mid-bit ±1 tick plus 2-clock synchronizer delay.
- Reset asserted mid-frame: both FSMs abort immediately to reset values; partial RX byte is lost.

## Configuration
- SPART_ERR_EN defined: status bits [2]=framing error and [3]=overrun, sticky, set on the event, cleared at the edge after a status read (set wins over clear on the same edge).
- Undefined: no error flops, status bits [3:2] read 0.

## Structure
- Package spart_pkg: ioaddr constants (ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH), OVERSAMPLE=16, tx_state_t, rx_state_t enums.
- Sub-module spart_baud_gen (div in, reload in, tick out); TX, RX and bus decode stay in spart.

## Test plan
- Reset → txd=1, tbr=1, rda=0, databus Z; read 10/11 → 8'h45/8'h01 (325).
- Write div 10=8'h01, 11=8'h00; write 00=8'hA5 → txd frame 0,1,0,1,0,0,1,0,1,1 each 32 clocks; tbr low for 320 clocks; second write during frame ignored.
- Loop txd→rxd, send 8'h3C → rda=1; read 00 → 8'h3C; rda=0 next cycle; status read → 8'h02.
- 3-tick low glitch on rxd → no rda, RX back to IDLE, subsequent byte 8'h81 received correctly.
- Stop bit forced low with byte 8'hFF → rda stays 0, rx_buf unchanged; with SPART_ERR_EN status bit 2=1, cleared after the read.
- Two bytes 8'h11, 8'h22 received without reading → rx_buf=8'h22, rda=1; with SPART_ERR_EN status bit 3=1.
